sipo: RTL and testbench
=======================

# sipo

Serial-in/parallel-out collector that reassembles 2-bit serial symbols, MSB first, into 16-bit words. It is the receive end of the 2-bit symbol stream produced by the parallel-to-serial stage. A completed word is presented to the downstream consumer through a valid/ready handshake. It sits between the symbol path and the word-wide consumer, and flags words lost to backpressure.

## Interface
- SYM_W, 2: bits per serial symbol.
- SYMS, 8: symbols per word; word width is SYM_W*SYMS = 16.
- clk  in  1  clock, all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous restart: drops partial word, output word and overflow flag.
- data_serial_i  in  SYM_W  incoming symbol; first symbol received lands in word bits [15:14].
- valid_serial_i  in  1  data_serial_i is valid this cycle; no ready/backpressure on this side.
- data_parallel_o  out  SYM_W*SYMS  assembled word, held stable while valid_parallel_o=1.
- valid_parallel_o  out  1  output word available.
- ready_parallel_i  in  1  consumer accepts the word on an edge where valid and ready are both 1.
- sym_cnt_o  out  3  symbols collected in the current partial word, 0..7.
- busy_o  out  1  partial word in progress (sym_cnt_o != 0).
- overflow_o  out  1  sticky: a completed word was dropped because the output register was occupied.

## Operation
- Two storage stages:
  - 16-bit shift register plus a 3-bit symbol counter.
  - 16-bit output register plus a valid flag.
- Accept: on an edge with valid_serial_i=1, shift <= {shift[13:0], data_serial_i} and the counter increments, wrapping 7 -> 0.
- Completion: the edge accepting the 8th symbol (counter == 7) forms the complete word {shift[13:0], data_serial_i}.
  - The word goes directly into the output register if the slot is free: valid_parallel_o=0, or valid&&ready on the same edge.
  - Otherwise the word is discarded, overflow_o <= 1, and the output register keeps the old word untouched.
- The counter always wraps to 0 on completion, whether the word was stored or dropped.
- Drain: valid&&ready with no completion on the same edge clears valid_parallel_o. data_parallel_o keeps its last value but is don't-care.
- Drain and completion on the same edge: the new word loads and valid_parallel_o stays 1. The consumer sees back-to-back words.
- Gaps (valid_serial_i=0) are permitted anywhere, for any length. The counter and shift register hold.
- clear_i has priority over everything on its edge:
  - counter, shift, valid_parallel_o and overflow_o go to 0;
  - any symbol presented on that edge is discarded;
  - any handshake on that edge is void.
- overflow_o clears only on clear_i or reset.

## Timing
- Reset values: data_parallel_o=0, valid_parallel_o=0, sym_cnt_o=0, busy_o=0, overflow_o=0. The shift register is also 0.
- Reset is asynchronous and effective immediately, including mid-word and while the output is valid. The partial word is lost.
- Latency: valid_parallel_o rises on the same edge that captures the 8th symbol. The word is visible in the cycle after that edge.
- Minimum spacing between output words: 8 cycles, with continuous valid_serial_i.
- Sustained throughput is 1 word per 8 cycles with no loss, provided ready_parallel_i is asserted within 8 cycles of valid_parallel_o.
- sym_cnt_o and busy_o are registered. They update on the accepting edge.
- All outputs are driven directly from registers; there is no combinational path from input to output.

## Test plan
- Single word:
  - Stimulus: ready=1; continuous symbols 10,10,01,01,11,00,00,11.
  - Response: data_parallel_o=16'hA5C3 with valid_parallel_o=1 for exactly one cycle. sym_cnt_o steps 1..7 then 0. overflow_o=0.
- Gapped input: same 8 symbols with valid_serial_i deasserted 3 cycles between every symbol -> identical word 16'hA5C3; the counter holds during gaps.
- Backpressure overflow:
  - Stimulus: ready=0; words 16'h1234 then 16'hFFFF streamed.
  - Response: after the second completion, output still 16'h1234 with valid=1, and overflow_o=1.
  - Raising ready for one cycle drains 16'h1234; valid goes to 0 and overflow_o remains 1.
- Simultaneous drain/complete:
  - Stimulus: word 16'h0001 pending; ready=1 asserted exactly on the edge of the 8th symbol of 16'h8000.
  - Response: output becomes 16'h8000, valid stays 1, no overflow.
- Clear mid-word:
  - Stimulus: 5 symbols sent, then clear_i pulsed together with a 6th symbol, then 8 fresh symbols of 16'hC3A5.
  - Response: sym_cnt_o=0 after the clear edge; the next word is exactly 16'hC3A5.
- Async reset mid-word:
  - Stimulus: rst_n pulsed low between clock edges after 4 symbols, with an output word valid.
  - Response: all outputs 0 immediately. The next 8 symbols produce a clean word with no residue from the earlier symbols.

Source files
------------

// File: rtl/sipo.sv
// sipo: serial-in/parallel-out collector.
// Reassembles SYM_W-bit serial symbols (MSB-first) into SYM_W*SYMS-bit words
// and offers each completed word on a valid/ready output port.
//
// Output handshake: the word on data_parallel_o is offered while
// valid_parallel_o=1 and stays stable until it is taken. It is taken on a
// rising edge where valid_parallel_o and ready_parallel_i are both 1.
// A word that completes while the output slot is still occupied (and not
// being drained on that same edge) is dropped, and overflow_o is set. The
// flag stays set until clear_i or reset.
module sipo #(
    parameter int SYM_W = 2,
    parameter int SYMS  = 8,
    localparam int W     = SYM_W * SYMS,
    localparam int CNT_W = $clog2(SYMS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic [SYM_W-1:0] data_serial_i,
    input  logic             valid_serial_i,
    output logic [W-1:0]     data_parallel_o,
    output logic             valid_parallel_o,
    input  logic             ready_parallel_i,
    output logic [CNT_W-1:0] sym_cnt_o,
    output logic             busy_o,
    output logic             overflow_o
);

    localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(SYMS - 1);

    logic [W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [W-1:0]     out_q,   out_d;
    logic             valid_q, valid_d;
    logic             ovf_q,   ovf_d;

    logic [W-1:0]     word_next;
    logic             drain;
    logic             complete;

    // Next-state logic: clear wins, then symbol accept/completion, then drain.
    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        word_next = {shift_q[W-SYM_W-1:0], data_serial_i};
        drain     = valid_q && ready_parallel_i;
        complete  = valid_serial_i && (cnt_q == LAST_SYM);

        if (clear_i) begin
            // The output data register is not cleared; it is don't-care
            // once valid drops.
            shift_d = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            if (valid_serial_i) begin
                shift_d = word_next;
                cnt_d   = complete ? '0 : cnt_q + CNT_W'(1);
            end

            if (complete) begin
                if (!valid_q || drain) begin
                    // The slot is free, or it is freed on this same edge,
                    // so the consumer sees back-to-back words.
                    out_d   = word_next;
                    valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (drain) begin
                valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_parallel_o  = out_q;
    assign valid_parallel_o = valid_q;
    assign sym_cnt_o        = cnt_q;
    assign busy_o           = (cnt_q != '0);
    assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_sipo.sv
// tb_sipo: vector table, directed corner sequences and a random stream,
// all checked against a queue-based reference model of the collector.
module tb_sipo;

    logic        clk;
    logic        rst_n;
    logic        clear_i;
    logic [1:0]  data_serial_i;
    logic        valid_serial_i;
    logic [15:0] data_parallel_o;
    logic        valid_parallel_o;
    logic        ready_parallel_i;
    logic [2:0]  sym_cnt_o;
    logic        busy_o;
    logic        overflow_o;

    int total = 0;
    int bad   = 0;

    sipo dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear_i          (clear_i),
        .data_serial_i    (data_serial_i),
        .valid_serial_i   (valid_serial_i),
        .data_parallel_o  (data_parallel_o),
        .valid_parallel_o (valid_parallel_o),
        .ready_parallel_i (ready_parallel_i),
        .sym_cnt_o        (sym_cnt_o),
        .busy_o           (busy_o),
        .overflow_o       (overflow_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          sym_q[$];
    logic [15:0] m_word;
    bit          m_valid;
    bit          m_ovf;

    task automatic model_reset();
        sym_q.delete();
        m_word  = 16'h0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge(input logic c, input logic vs, input logic [1:0] d, input logic r);
        int  w;
        bit  taken;
        bit  done;
        if (c) begin
            sym_q.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            taken = m_valid && r;
            done  = 1'b0;
            if (vs) begin
                sym_q.push_back(int'(d));
                if (sym_q.size() == 8) begin
                    w = 0;
                    foreach (sym_q[i]) w = w * 4 + sym_q[i];
                    sym_q.delete();
                    done = 1'b1;
                    if (!m_valid || taken) begin
                        m_word  = 16'(w);
                        m_valid = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            if (!done && taken) m_valid = 1'b0;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("valid", 32'(valid_parallel_o), 32'(m_valid));
        chk("sym_cnt", 32'(sym_cnt_o), 32'(sym_q.size()));
        chk("busy", 32'(busy_o), 32'(sym_q.size() != 0));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
        if (m_valid) chk("data", 32'(data_parallel_o), 32'(m_word));
    endtask

    // ---------------- drivers ----------------
    task automatic step(input logic c, input logic vs, input logic [1:0] d, input logic r);
        clear_i          = c;
        valid_serial_i   = vs;
        data_serial_i    = d;
        ready_parallel_i = r;
        @(posedge clk);
        model_edge(c, vs, d, r);
        #1;
        chk_model();
    endtask

    task automatic send_word(input logic [15:0] w, input logic r, input int gap);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, w[15-2*i -: 2], r);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 2'b00, r);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        c;
        logic        vs;
        logic [1:0]  d;
        logic        r;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [2:0]  exp_cnt;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[9];
    logic [1:0] syms[8];

    initial begin
        // Single word 16'hA5C3 with ready held high.
        syms = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11};
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b0, 1'b1, syms[i], 1'b1, (i == 7), 16'hA5C3, 3'((i + 1) % 8), 1'b0};
        tbl[8] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 16'hA5C3, 3'd0, 1'b0};

        // ---- reset ----
        rst_n            = 1'b0;
        clear_i          = 1'b0;
        valid_serial_i   = 1'b0;
        data_serial_i    = 2'b00;
        ready_parallel_i = 1'b0;
        model_reset();
        #12;
        chk("rst_data", 32'(data_parallel_o), 32'h0);
        chk("rst_valid", 32'(valid_parallel_o), 32'h0);
        chk("rst_cnt", 32'(sym_cnt_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_ovf", 32'(overflow_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table: single word ----
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].c, tbl[i].vs, tbl[i].d, tbl[i].r);
            chk("tbl_valid", 32'(valid_parallel_o), 32'(tbl[i].exp_valid));
            chk("tbl_cnt", 32'(sym_cnt_o), 32'(tbl[i].exp_cnt));
            chk("tbl_ovf", 32'(overflow_o), 32'(tbl[i].exp_ovf));
            if (tbl[i].exp_valid) chk("tbl_data", 32'(data_parallel_o), 32'(tbl[i].exp_data));
        end

        // ---- gapped input ----
        send_word(16'hA5C3, 1'b0, 3);
        chk("gap_data", 32'(data_parallel_o), 32'hA5C3);
        chk("gap_valid", 32'(valid_parallel_o), 32'h1);
        step(1'b0, 1'b0, 2'b00, 1'b1);
        chk("gap_drain", 32'(valid_parallel_o), 32'h0);

        // ---- backpressure overflow ----
        send_word(16'h1234, 1'b0, 0);
        send_word(16'hFFFF, 1'b0, 0);
        chk("ovf_data", 32'(data_parallel_o), 32'h1234);
        chk("ovf_valid", 32'(valid_parallel_o), 32'h1);
        chk("ovf_flag", 32'(overflow_o), 32'h1);
        step(1'b0, 1'b0, 2'b00, 1'b1);
        chk("ovf_drain_valid", 32'(valid_parallel_o), 32'h0);
        chk("ovf_sticky", 32'(overflow_o), 32'h1);
        step(1'b1, 1'b0, 2'b00, 1'b0);
        chk("ovf_clear", 32'(overflow_o), 32'h0);

        // ---- simultaneous drain and complete ----
        send_word(16'h0001, 1'b0, 0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, (i == 0) ? 2'b10 : 2'b00, 1'b0);
        step(1'b0, 1'b1, 2'b00, 1'b1);
        chk("b2b_data", 32'(data_parallel_o), 32'h8000);
        chk("b2b_valid", 32'(valid_parallel_o), 32'h1);
        chk("b2b_ovf", 32'(overflow_o), 32'h0);
        step(1'b0, 1'b0, 2'b00, 1'b1);

        // ---- clear mid-word ----
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'(i), 1'b1);
        step(1'b1, 1'b1, 2'b11, 1'b1);
        chk("clr_cnt", 32'(sym_cnt_o), 32'h0);
        send_word(16'hC3A5, 1'b0, 0);
        chk("clr_word", 32'(data_parallel_o), 32'hC3A5);
        chk("clr_valid", 32'(valid_parallel_o), 32'h1);

        // ---- async reset mid-word, output still valid ----
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b11, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_data", 32'(data_parallel_o), 32'h0);
        chk("arst_valid", 32'(valid_parallel_o), 32'h0);
        chk("arst_cnt", 32'(sym_cnt_o), 32'h0);
        chk("arst_busy", 32'(busy_o), 32'h0);
        chk("arst_ovf", 32'(overflow_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(16'h5A5A, 1'b1, 0);
        chk("arst_word", 32'(data_parallel_o), 32'h5A5A);
        step(1'b0, 1'b0, 2'b00, 1'b1);

        // ---- random stream against the model ----
        for (int n = 0; n < 800; n++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 9) < 7),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
